// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's hazard/branch inputs, the instruction-memory port and the IF/ID outputs.
// "master" is the fetch stage side and "slave" is the surrounding core or memory side.
interface fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             br_taken;
  logic [63:0]      br_target;
  logic [63:0]      imem_addr;
  logic [31:0]      imem_inst;
  logic [63:0]      ifid_pc;
  logic [31:0]      ifid_inst;
  logic             ifid_valid;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, br_taken, br_target, imem_inst,
    output imem_addr, ifid_pc, ifid_inst, ifid_valid, fetch_count
  );

  modport slave (
    output stall, br_taken, br_target, imem_inst,
    input  imem_addr, ifid_pc, ifid_inst, ifid_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives imem_addr = pc, and latches the fetched instruction into IF/ID one edge later.
// A stall freezes PC, IF/ID and the counter; a taken branch redirects and inserts a single NOP bubble.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'hD503201F,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fif
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_inst_q, ifid_inst_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'h0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    cnt_d        = cnt_q;
    case (state_q)
      // One idle edge after reset so instruction memory can settle on RESET_PC.
      BOOT: state_d = RUN;
      RUN: begin
        if (fif.br_taken) begin
          pc_d         = {fif.br_target[63:2], 2'b00};
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
        end else if (!fif.stall) begin
          ifid_pc_d    = pc_q;
          ifid_inst_d  = fif.imem_inst;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 64'd4;
          // Saturating: the counter sticks at all-ones rather than wrapping.
          if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign fif.imem_addr   = pc_q;
  assign fif.ifid_pc     = ifid_pc_q;
  assign fif.ifid_inst   = ifid_inst_q;
  assign fif.ifid_valid  = ifid_valid_q;
  assign fif.fetch_count = cnt_q;

endmodule
